// File: rtl/device_uart_rx_if.sv
// Peripheral bus port shared by the UART devices: register write/read strobes,
// addresses and data. The read data is returned one cycle after ren.
interface bus_if;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        ren;
  logic [31:0] raddr;
  logic [31:0] rdata;

  modport master (output wen, waddr, wdata, ren, raddr, input rdata);
  modport slave  (input wen, waddr, wdata, ren, raddr, output rdata);
endinterface

// File: rtl/device_uart_rx.sv
// Bus-mapped 8N1 UART receiver with a byte FIFO and STATUS/DATA registers.
// Optional interrupt output and enable bit are built when UART_RX_IRQ_EN is defined.
module device_uart_rx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic RxD,
  bus_if.slave bus
`ifdef UART_RX_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync_q, rxs_q;
  logic            stop_ok, stop_bad;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            overrun_q, frame_err_q;
  logic [31:0]     rdata_q;
  logic            ie_q;

  // Receiver FSM: the counter restarts at each state change so samples land mid-bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          stop_ok  = rxs_q;
          stop_bad = !rxs_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic        avail, full, pop, push, ovr_set, status_wr;
  logic [31:0] count_ext;
  logic [3:0]  fill;
  logic [31:0] status;

  assign avail     = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = bus.ren & bus.raddr[2] & avail;
  // A full FIFO still accepts a byte when the same edge pops the head.
  assign push      = stop_ok & (!full | pop);
  assign ovr_set   = stop_ok & full & !pop;
  assign status_wr = bus.wen & !bus.waddr[2];
  assign count_ext = 32'(count_q);
  assign fill      = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];

  always_comb begin
    status    = '0;
    status[0] = avail;
    status[1] = overrun_q;
    status[2] = frame_err_q;
    status[7:4] = fill;
    status[8] = ie_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      sync_q      <= 1'b1;
      rxs_q       <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sync_q   <= RxD;
      rxs_q    <= sync_q;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CNTW'(1);
      else if (pop && !push) count_q <= count_q - CNTW'(1);
      // Flag set takes priority over a same-edge W1C clear.
      overrun_q   <= ovr_set  | (overrun_q   & !(status_wr & bus.wdata[1]));
      frame_err_q <= stop_bad | (frame_err_q & !(status_wr & bus.wdata[2]));
      if (bus.ren) begin
        if (bus.raddr[2]) rdata_q <= avail ? {24'h0, mem_q[rd_ptr_q]} : 32'h0;
        else              rdata_q <= status;
      end
    end
  end

`ifdef UART_RX_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (status_wr) ie_q <= bus.wdata[8];
      irq_q <= ie_q & (avail | overrun_q | frame_err_q);
    end
  end
  assign irq = irq_q;
`else
  assign ie_q = 1'b0;
`endif

  assign bus.rdata = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{bus.waddr[31:3], bus.waddr[1:0], bus.raddr[31:3],
                         bus.raddr[1:0], bus.wdata[31:9], bus.wdata[8], bus.wdata[7:3],
                         bus.wdata[0]};
endmodule

// File: tb/tb_device_uart_rx.sv
// Randomised scoreboard bench for device_uart_rx: frames are driven on RxD and a
// byte-queue model of the receiver predicts every STATUS/DATA read.
module tb_device_uart_rx;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic RxD = 1'b1;
  bus_if bus();
`ifdef UART_RX_IRQ_EN
  logic irq;
`endif

  device_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .RxD(RxD),
    .bus(bus)
`ifdef UART_RX_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];
  exp_t exp_e;
  logic [7:0] mfifo[$];
  bit m_ovr = 0, m_fe = 0, m_ie = 0;
  logic rvalid_q = 1'b0;

  always @(posedge clk) rvalid_q <= bus.ren;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every read returns one cycle after ren and is matched in issue order.
  always @(negedge clk) begin
    if (rvalid_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %08h expected no read", bus.rdata);
      end else begin
        exp_e = exp_q.pop_front();
        check(exp_e.name, bus.rdata, exp_e.val);
      end
    end
  end

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int n;
    s = '0;
    n = mfifo.size();
    s[0] = (n != 0);
    s[1] = m_ovr;
    s[2] = m_fe;
    s[7:4] = (n > 15) ? 4'd15 : 4'(n);
`ifdef UART_RX_IRQ_EN
    s[8] = m_ie;
`endif
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mfifo.delete();
    m_ovr = 0;
    m_fe  = 0;
    m_ie  = 0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input string name);
    exp_t e;
    e.name = name;
    if (addr[2]) e.val = (mfifo.size() != 0) ? {24'h0, mfifo.pop_front()} : 32'h0;
    else         e.val = model_status();
    exp_q.push_back(e);
    bus.ren   = 1'b1;
    bus.raddr = addr;
    tick();
    bus.ren   = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    if (!addr[2]) begin
      if (data[1]) m_ovr = 0;
      if (data[2]) m_fe  = 0;
`ifdef UART_RX_IRQ_EN
      m_ie = data[8];
`endif
    end
    bus.wen   = 1'b1;
    bus.waddr = addr;
    bus.wdata = data;
    tick();
    bus.wen   = 1'b0;
  endtask

  // abort_bit < 8 pulses reset in the middle of that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input int abort_bit);
    RxD = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        RxD = b[i];
        repeat (DIV / 2) tick();
        rst = 1'b0;
        RxD = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        model_reset();
        return;
      end
      RxD = b[i];
      repeat (DIV) tick();
    end
    RxD = bad_stop ? 1'b0 : 1'b1;
    repeat (DIV) tick();
    RxD = 1'b1;
    repeat (2 * DIV) tick();
    if (bad_stop)                m_fe = 1;
    else if (mfifo.size() < DEPTH) mfifo.push_back(b);
    else                         m_ovr = 1;
  endtask

  initial begin
    int r;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    bus.waddr = '0;
    bus.raddr = '0;
    bus.wdata = '0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("reset_rdata", bus.rdata, 32'h0);
    bus_read(32'h0, "reset_status");

    send_frame(8'hA5, 0, 8);
    bus_read(32'h0, "a5_status");
    bus_read(32'h4, "a5_data");
    bus_read(32'h0, "a5_status_after");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 8);
    bus_read(32'h0, "overrun_status");
    for (int i = 0; i < 8; i++) bus_read(32'h4, "overrun_data");
    bus_read(32'h4, "empty_data");
    bus_write(32'h0, 32'h2);
    bus_read(32'h0, "overrun_cleared");

    send_frame(8'h3C, 1, 8);
    bus_read(32'h0, "frame_err_status");
    send_frame(8'h55, 0, 8);
    bus_read(32'h4, "after_ferr_data");
    bus_write(32'h0, 32'h4);
    bus_read(32'h0, "ferr_cleared");

    RxD = 1'b0;
    repeat (3) tick();
    RxD = 1'b1;
    repeat (2 * DIV) tick();
    bus_read(32'h0, "glitch_status");

    send_frame(8'h11, 0, 8);
    send_frame(8'h22, 0, 8);
    bus_read(32'h4, "pre_reset_data");
    send_frame(8'hC3, 0, 4);
    tick();
    check("midframe_rst_rdata", bus.rdata, 32'h0);
    bus_read(32'h0, "midframe_rst_status");
    send_frame(8'h7E, 0, 8);
    bus_read(32'h4, "after_rst_data");

`ifdef UART_RX_IRQ_EN
    check("irq_idle", {31'h0, irq}, 32'h0);
    bus_write(32'h0, 32'h100);
    send_frame(8'h42, 0, 8);
    check("irq_high", {31'h0, irq}, 32'h1);
    bus_read(32'h4, "irq_data");
    check("irq_hold_after_pop", {31'h0, irq}, 32'h1);
    tick();
    check("irq_low", {31'h0, irq}, 32'h0);
    bus_write(32'h0, 32'h0);
`endif

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      send_frame(8'($urandom), (r == 5), 8);
      else if (r <= 7) bus_read(32'h4, "rand_data");
      else if (r == 8) bus_read(32'h0, "rand_status");
      else             bus_write(32'h0, $urandom & 32'h106);
    end
    bus_read(32'h0, "final_status");

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/device_uart_rx.md
Name: device_uart_rx

Overview:
Bus-mapped UART receiver, the receive-direction counterpart of the console UART device. Deserialises 8N1 frames from the RxD pin, buffers bytes in a small FIFO and exposes status and data registers on the bus_if slave port. Sits on the peripheral bus alongside the transmit-side UART device.

Parameters:
CLK_HZ, 50000000, clk frequency in Hz
BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer division), must be >= 4
FIFO_DEPTH, 8, receive FIFO entries; power of 2, >= 2

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
RxD  input  1  asynchronous serial input, idle high
bus  bus_if.slave  -  uses wen, waddr, wdata[31:0], ren, raddr, rdata[31:0]
irq  output  1  present only with UART_RX_IRQ_EN

Behaviour:
- Reset (rst==0 at posedge clk): rdata=0, FIFO empty, overrun=0, frame_err=0, rx FSM=IDLE, baud counter=0, synchroniser flops=1, irq=0.
- RxD passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rxs==0 -> START, counter=0.
  - START: at counter==DIV/2-1 sample rxs; 0 -> DATA (bit index 0, counter reset); 1 -> IDLE (glitch, no flags change).
  - DATA: every DIV cycles sample rxs into shift reg, LSB first; after bit 7 -> STOP.
  - STOP: after DIV cycles sample rxs; 1 -> push byte if FIFO not full, else drop byte and set overrun; 0 -> drop byte, set frame_err. Then -> IDLE.
- Push takes effect at the clock edge of the stop-bit sample.
- Register map (decode on address bit 2, other bits ignored):
  - offset 0 STATUS read: bit0 rx_avail (FIFO non-empty), bit1 overrun, bit2 frame_err, bits[7:4] fill count saturated to 15, rest 0.
  - offset 0 write: wdata bit1=1 clears overrun, bit2=1 clears frame_err (W1C); other bits ignored.
  - offset 4 DATA read: rdata={24'h0, head byte} and pop; empty FIFO returns 0, no pop, no error.
  - offset 4 write: ignored.
- Read latency: rdata registered, valid the cycle after ren; rdata holds its value when ren==0.
- STATUS read reflects state before the same-edge push/pop.
- Simultaneous push and pop: both occur, count unchanged; a push into a full FIFO with a same-cycle pop is accepted (no overrun).
- Simultaneous W1C clear and flag set on the same edge: set wins.
- Simultaneous wen and ren: both serviced.
- FIFO pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-frame: frame abandoned, FSM to IDLE, no push.

Optional Feature:
UART_RX_IRQ_EN: adds output irq and an interrupt-enable bit ie at STATUS bit 8 (read/write, reset 0). irq is registered: irq = ie & (rx_avail | overrun | frame_err), one cycle after the condition changes. Without the macro: no irq port, bit 8 reads 0, writes to it ignored.

Test Plan:
- CLK_HZ=1000000, BAUD=100000 (DIV=10): send 0xA5, read STATUS -> 0x00000011; read DATA -> 0x000000A5; read STATUS -> 0x00000000.
- Send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 and no reads -> STATUS bit1=1, count=8; eight DATA reads return 0x01..0x08; write STATUS 0x2 -> bit1=0.
- Send 0x3C with stop bit driven 0 -> frame_err=1, FIFO empty; the next valid byte 0x55 is received correctly.
- 3-cycle low glitch on RxD -> returns to IDLE, STATUS stays 0x00000000.
- Assert rst during bit 4 of a frame -> all registers return to reset values; the following frame 0x7E is received correctly.
- With UART_RX_IRQ_EN: write STATUS 0x100, send 0x42 -> irq rises within 1 cycle of the push; DATA read -> irq falls the cycle after the pop.
